// File: rtl/pipe_exe_stage_pkg.sv
// ---------------------------------------------------------------------------
// pipe_exe_stage_pkg
// Shared CPU definitions used by the execute stage: the ALU operation codes
// and the link register number written by jal.
// ---------------------------------------------------------------------------
package pipe_exe_stage_pkg;

  // ALU operation codes. For add/sub/and/or/xor/lui the top bit is a don't
  // care. Shifts use the full 4-bit code.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  // Destination register of jal (return address).
  localparam logic [4:0] LINK_REG = 5'd31;

endpackage

// File: rtl/pipe_exe_stage_alu.sv
// ---------------------------------------------------------------------------
// pipe_alu
// Purely combinational ALU of the execute stage.
//   a_i    : A operand (shift amount taken from a_i[4:0] for shifts)
//   b_i    : B operand (value shifted for shifts)
//   aluc_i : operation code (see pipe_exe_stage_pkg)
//   r_o    : result; unused codes give 0
// ---------------------------------------------------------------------------
module pipe_alu
  import pipe_exe_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       aluc_i,
  output logic [WIDTH-1:0] r_o
);

  logic        [4:0]       sh;
  logic signed [WIDTH-1:0] b_s;

  assign sh  = a_i[4:0];
  assign b_s = b_i;

  always_comb begin
    r_o = '0;
    // The low three bits select the operation; bit 3 only matters for shifts.
    case (aluc_i[2:0])
      ALU_ADD[2:0]: r_o = a_i + b_i;
      ALU_SUB[2:0]: r_o = a_i - b_i;
      ALU_AND[2:0]: r_o = a_i & b_i;
      ALU_OR[2:0]:  r_o = a_i | b_i;
      ALU_XOR[2:0]: r_o = a_i ^ b_i;
      ALU_LUI[2:0]: r_o = b_i << 16;
      ALU_SLL[2:0]: begin
        // 1011 is not a legal shift and yields 0.
        if (aluc_i == ALU_SLL) r_o = b_i << sh;
        else                   r_o = '0;
      end
      default: begin
        if (aluc_i == ALU_SRA) r_o = b_s >>> sh;
        else                   r_o = b_i >> sh;
      end
    endcase
  end

endmodule

// File: rtl/pipe_exe_stage.sv
// ---------------------------------------------------------------------------
// pipe_exe_stage
// Execute stage of the five-stage pipeline: ID/EXE register plus ALU. Also
// drives the forwarding/hazard return path back to decode.
//   clock, resetn          : clock, asynchronous active-low reset
//   wpcir                  : decode advance enable, 0 inserts a bubble
//   dwreg/dm2reg/dwmem     : decoded regfile-write / load / store controls
//   daluc/daluimm/dshift   : ALU op and operand selects
//   djal                   : jal, result = pc4+4 into r31
//   da/db/dimm/dpc4/drn    : operands, immediate, PC+4, destination
//   ewreg/em2reg/ewmem/ern : registered controls and effective destination
//   ealu                   : ALU result or link address (combinational)
//   eb                     : registered db (store data)
// ---------------------------------------------------------------------------
module pipe_exe_stage
  import pipe_exe_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             wpcir,
  input  logic             dwreg,
  input  logic             dm2reg,
  input  logic             dwmem,
  input  logic [3:0]       daluc,
  input  logic             daluimm,
  input  logic             dshift,
  input  logic             djal,
  input  logic [WIDTH-1:0] da,
  input  logic [WIDTH-1:0] db,
  input  logic [WIDTH-1:0] dimm,
  input  logic [WIDTH-1:0] dpc4,
  input  logic [4:0]       drn,
  output logic             ewreg,
  output logic             em2reg,
  output logic             ewmem,
  output logic [4:0]       ern,
  output logic [WIDTH-1:0] ealu,
  output logic [WIDTH-1:0] eb
);

  logic             wreg_d,   wreg_q;
  logic             m2reg_d,  m2reg_q;
  logic             wmem_d,   wmem_q;
  logic [3:0]       aluc_d,   aluc_q;
  logic             aluimm_d, aluimm_q;
  logic             shift_d,  shift_q;
  logic             jal_d,    jal_q;
  logic [WIDTH-1:0] a_d,      a_q;
  logic [WIDTH-1:0] b_d,      b_q;
  logic [WIDTH-1:0] imm_d,    imm_q;
  logic [WIDTH-1:0] pc4_d,    pc4_q;
  logic [4:0]       rn_d,     rn_q;

  logic [WIDTH-1:0] alua, alub, alu_r;

  // A stall slot enters EXE as a bubble: every control that could write
  // state or match in forwarding is cleared. Data fields load regardless.
  always_comb begin
    wreg_d   = wpcir & dwreg;
    m2reg_d  = wpcir & dm2reg;
    wmem_d   = wpcir & dwmem;
    jal_d    = wpcir & djal;
    rn_d     = wpcir ? drn : 5'd0;
    aluc_d   = daluc;
    aluimm_d = daluimm;
    shift_d  = dshift;
    a_d      = da;
    b_d      = db;
    imm_d    = dimm;
    pc4_d    = dpc4;
  end

  // ID/EXE register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wreg_q   <= 1'b0;
      m2reg_q  <= 1'b0;
      wmem_q   <= 1'b0;
      aluc_q   <= 4'd0;
      aluimm_q <= 1'b0;
      shift_q  <= 1'b0;
      jal_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      pc4_q    <= '0;
      rn_q     <= 5'd0;
    end else begin
      wreg_q   <= wreg_d;
      m2reg_q  <= m2reg_d;
      wmem_q   <= wmem_d;
      aluc_q   <= aluc_d;
      aluimm_q <= aluimm_d;
      shift_q  <= shift_d;
      jal_q    <= jal_d;
      a_q      <= a_d;
      b_q      <= b_d;
      imm_q    <= imm_d;
      pc4_q    <= pc4_d;
      rn_q     <= rn_d;
    end
  end

  // Shift instructions take the amount from the sa field of the immediate.
  assign alua = shift_q  ? {{(WIDTH-5){1'b0}}, imm_q[10:6]} : a_q;
  assign alub = aluimm_q ? imm_q : b_q;

  pipe_alu #(.WIDTH(WIDTH)) u_alu (
    .a_i    (alua),
    .b_i    (alub),
    .aluc_i (aluc_q),
    .r_o    (alu_r)
  );

  assign ealu   = jal_q ? (pc4_q + WIDTH'(4)) : alu_r;
  assign ern    = jal_q ? LINK_REG : rn_q;
  assign ewreg  = wreg_q;
  assign em2reg = m2reg_q;
  assign ewmem  = wmem_q;
  assign eb     = b_q;

endmodule

// File: tb/tb_pipe_exe_stage.sv
module tb_pipe_exe_stage;

  typedef struct packed {
    bit        wreg, m2reg, wmem;
    bit [3:0]  aluc;
    bit        aluimm, shift, jal;
    bit [31:0] a, b, imm, pc4;
    bit [4:0]  rn;
  } ins_t;

  typedef struct packed {
    bit        ewreg, em2reg, ewmem;
    bit [4:0]  ern;
    bit [31:0] ealu, eb;
  } exp_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic        wpcir;
  logic        dwreg, dm2reg, dwmem, daluimm, dshift, djal;
  logic [3:0]  daluc;
  logic [31:0] da, db, dimm, dpc4;
  logic [4:0]  drn;
  logic        ewreg, em2reg, ewmem;
  logic [4:0]  ern;
  logic [31:0] ealu, eb;

  int n_checks = 0;
  int n_fail   = 0;

  ins_t cur;
  bit   cur_w;

  always #5 clock = ~clock;

  pipe_exe_stage #(.WIDTH(32)) dut (
    .clock(clock), .resetn(resetn), .wpcir(wpcir),
    .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem),
    .daluc(daluc), .daluimm(daluimm), .dshift(dshift), .djal(djal),
    .da(da), .db(db), .dimm(dimm), .dpc4(dpc4), .drn(drn),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ern(ern), .ealu(ealu), .eb(eb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference ALU written from the operation table.
  function automatic bit [31:0] ref_alu(bit [3:0] op, bit [31:0] a, bit [31:0] b);
    int s;
    bit [31:0] ones;
    s = int'(a % 32);
    ones = 32'hFFFF_FFFF;
    if (op == 4'd3)  return b << s;
    if (op == 4'd7)  return b >> s;
    if (op == 4'd15) return (b >> s) | (b[31] ? ~(ones >> s) : 32'd0);
    if (op == 4'd11) return 32'd0;
    case (op % 8)
      0: return a + b;
      4: return a - b;
      1: return a & b;
      5: return a | b;
      2: return a ^ b;
      6: return (b % 65536) * 65536;
      default: return 32'd0;
    endcase
  endfunction

  function automatic exp_t golden(ins_t x, bit w);
    exp_t e;
    bit [31:0] opa, opb;
    bit jal;
    opa = x.shift ? ((x.imm >> 6) % 32) : x.a;
    opb = x.aluimm ? x.imm : x.b;
    jal = w && x.jal;
    e.ewreg  = w && x.wreg;
    e.em2reg = w && x.m2reg;
    e.ewmem  = w && x.wmem;
    e.ern    = jal ? 5'd31 : (w ? x.rn : 5'd0);
    e.ealu   = jal ? x.pc4 + 32'd4 : ref_alu(x.aluc, opa, opb);
    e.eb     = x.b;
    return e;
  endfunction

  task automatic drive(input ins_t x, input bit w);
    cur = x; cur_w = w;
    wpcir = w;
    dwreg = x.wreg; dm2reg = x.m2reg; dwmem = x.wmem;
    daluc = x.aluc; daluimm = x.aluimm; dshift = x.shift; djal = x.jal;
    da = x.a; db = x.b; dimm = x.imm; dpc4 = x.pc4; drn = x.rn;
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".ewreg"},  {31'd0, ewreg},  {31'd0, e.ewreg});
    chk({tag, ".em2reg"}, {31'd0, em2reg}, {31'd0, e.em2reg});
    chk({tag, ".ewmem"},  {31'd0, ewmem},  {31'd0, e.ewmem});
    chk({tag, ".ern"},    {27'd0, ern},    {27'd0, e.ern});
    chk({tag, ".ealu"},   ealu,            e.ealu);
    chk({tag, ".eb"},     eb,              e.eb);
  endtask

  // Clock the currently driven slot in and compare against the model.
  task automatic step(input string tag);
    @(posedge clock);
    #1;
    chk_out(tag, golden(cur, cur_w));
  endtask

  // Pulse reset in the middle of a cycle; outputs must clear before any edge.
  task automatic mid_reset(input string tag);
    #2 resetn = 1'b0;
    #1 chk_out(tag, '0);
    #1 resetn = 1'b1;
  endtask

  function automatic ins_t rand_ins();
    ins_t x;
    x.wreg = 1'($urandom); x.m2reg = 1'($urandom); x.wmem = 1'($urandom);
    x.aluc = 4'($urandom); x.aluimm = 1'($urandom); x.shift = 1'($urandom);
    x.jal = ($urandom_range(0, 5) == 0);
    x.a = $urandom; x.b = $urandom; x.imm = $urandom; x.pc4 = $urandom;
    x.rn = 5'($urandom);
    return x;
  endfunction

  initial begin
    ins_t x;
    x = '0;
    resetn = 1'b0;
    drive(x, 1'b1);
    #2 chk_out("reset", '0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;

    // add overflow wraps
    x = '0; x.a = 32'h7FFF_FFFF; x.b = 32'h1; x.aluc = 4'b0000; x.wreg = 1; x.rn = 5'd3;
    drive(x, 1); step("add");
    chk("add.lit", ealu, 32'h8000_0000);
    // sub 0 - 1
    x = '0; x.a = 32'h0; x.b = 32'h1; x.aluc = 4'b0100;
    drive(x, 1); step("sub");
    chk("sub.lit", ealu, 32'hFFFF_FFFF);
    // sra / srl with shamt from imm[10:6]=4
    x = '0; x.shift = 1; x.imm = 32'd4 << 6; x.b = 32'h8000_0000; x.aluc = 4'b1111;
    drive(x, 1); step("sra");
    chk("sra.lit", ealu, 32'hF800_0000);
    x.aluc = 4'b0111;
    drive(x, 1); step("srl");
    chk("srl.lit", ealu, 32'h0800_0000);
    // lui
    x = '0; x.aluimm = 1; x.imm = 32'h0000_1234; x.aluc = 4'b0110;
    drive(x, 1); step("lui");
    chk("lui.lit", ealu, 32'h1234_0000);
    // jal
    x = '0; x.jal = 1; x.wreg = 1; x.pc4 = 32'h0040_0010; x.rn = 5'd0;
    drive(x, 1); step("jal");
    chk("jal.ealu", ealu, 32'h0040_0014);
    chk("jal.ern", {27'd0, ern}, 32'd31);
    chk("jal.ewreg", {31'd0, ewreg}, 32'd1);
    // asynchronous reset mid-cycle
    mid_reset("rst_mid");

    // load-use bubble
    x = '0; x.m2reg = 1; x.wreg = 1; x.rn = 5'd8; x.a = 32'h100; x.imm = 32'h4; x.aluimm = 1;
    drive(x, 1); step("lw");
    chk("lw.em2reg", {31'd0, em2reg}, 32'd1);
    chk("lw.ern", {27'd0, ern}, 32'd8);
    x = '0; x.wreg = 1; x.wmem = 1; x.rn = 5'd9; x.a = 32'h5; x.b = 32'h6; x.aluc = 4'b0001;
    drive(x, 0); step("bubble");
    chk("bubble.em2reg", {31'd0, em2reg}, 32'd0);
    chk("bubble.ern", {27'd0, ern}, 32'd0);
    drive(x, 1); step("held");
    chk("held.ern", {27'd0, ern}, 32'd9);
    chk("held.ewmem", {31'd0, ewmem}, 32'd1);
    // two consecutive bubbles, then reset with a bubble in flight
    x.aluc = 4'b0101;
    drive(x, 0); step("bub2a");
    drive(x, 0); step("bub2b");
    chk("bub2b.ealu", ealu, 32'h7);
    mid_reset("rst_bubble");
    drive(x, 1); step("after_rst");

    // randomized traffic with occasional bubbles and resets
    for (int i = 0; i < 400; i++) begin
      drive(rand_ins(), $urandom_range(0, 3) != 0);
      step($sformatf("rnd%0d", i));
      if ($urandom_range(0, 30) == 0) mid_reset($sformatf("rnd_rst%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
